p_mac_pipe: RTL and testbench

Parametrised, pipelined multiply / multiply-accumulate unit. It is the successor of the fixed-width (a+b)*c pipeline.
- Computes (a+b)*c or a*c per beat, optionally accumulating into an internal accumulator.
- Full valid/ready backpressure on input and output.
- Sits between a producer stream and a consumer that may stall; one beat per cycle when not stalled.

---
 rtl/p_mac_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_p_mac_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_mac_pipe.sv
// Pipelined unsigned multiply / multiply-accumulate unit with valid/ready on both sides.
// Computes (a+b)*c or a*c per beat through five register stages (S0..S4); accumulate
// modes fold the product into an OUT_W-bit accumulator held at S4.
// C_W >= IN_W+1 and C_W % LIMB_W == 0 are assumed by the limb split below.
module p_mac_pipe #(
    parameter int unsigned IN_W   = 47,
    parameter int unsigned C_W    = 48,
    parameter int unsigned LIMB_W = 12,
    localparam int unsigned OUT_W = 2 * C_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic [C_W-1:0]   in_c,
    input  logic [1:0]       in_mode,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_acc
);

    localparam int unsigned NL   = C_W / LIMB_W;            // limbs per operand
    localparam int unsigned PP_W = 2 * LIMB_W;              // limb partial product width
    localparam int unsigned ND   = 2 * NL - 1;              // number of diagonals
    localparam int unsigned DS_W = PP_W + $clog2(NL) + 1;   // diagonal sum width, no overflow

    logic stall;
    logic adv;

    // S0: registered inputs
    logic              s0_valid_q;
    logic [IN_W-1:0]   s0_a_q;
    logic [IN_W-1:0]   s0_b_q;
    logic [C_W-1:0]    s0_c_q;
    logic [1:0]        s0_mode_q;
    logic              s0_clr_q;

    // S1: operand pair
    logic              s1_valid_q;
    logic [C_W-1:0]    s1_op_q;
    logic [C_W-1:0]    s1_c_q;
    logic [1:0]        s1_mode_q;
    logic              s1_clr_q;
    logic [IN_W:0]     s1_sum;
    logic [C_W-1:0]    s1_op_d;

    // S2: limb partial products, pp[i][j] lies on diagonal i+j
    logic              s2_valid_q;
    logic [1:0]        s2_mode_q;
    logic              s2_clr_q;
    logic [PP_W-1:0]   pp_q [NL][NL];
    logic [PP_W-1:0]   pp_d [NL][NL];

    // S3: reduced diagonal sums
    logic              s3_valid_q;
    logic [1:0]        s3_mode_q;
    logic              s3_clr_q;
    logic [DS_W-1:0]   ds_q [ND];
    logic [DS_W-1:0]   ds_d [ND];

    // S4: output register and accumulator
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_q;
    logic              out_acc_q;
    logic [OUT_W-1:0]  acc_q;
    logic [OUT_W-1:0]  out_d;
    logic              out_acc_d;
    logic [OUT_W-1:0]  acc_d;
    logic [OUT_W-1:0]  prod;
    logic [OUT_W-1:0]  acc_sum;

    // Handshake: the whole pipe freezes only while a presented result is refused
    always_comb begin
        stall    = out_valid_q && !out_ready;
        adv      = !stall;
        in_ready = !stall;
    end

    // S0 register: capture the incoming beat (bubble when in_valid is low)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_c_q     <= '0;
            s0_mode_q  <= '0;
            s0_clr_q   <= 1'b0;
        end else if (adv) begin
            s0_valid_q <= in_valid;
            s0_a_q     <= in_a;
            s0_b_q     <= in_b;
            s0_c_q     <= in_c;
            s0_mode_q  <= in_mode;
            s0_clr_q   <= in_clr;
        end
    end

    // S1 next state: a+b at IN_W+1 bits, or a alone for the a*c modes
    always_comb begin
        s1_sum  = {1'b0, s0_a_q} + {1'b0, s0_b_q};
        s1_op_d = s0_mode_q[0] ? C_W'(s0_a_q) : C_W'(s1_sum);
    end

    // S1 register: operand pair plus control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_c_q     <= '0;
            s1_mode_q  <= '0;
            s1_clr_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= s0_valid_q;
            s1_op_q    <= s1_op_d;
            s1_c_q     <= s0_c_q;
            s1_mode_q  <= s0_mode_q;
            s1_clr_q   <= s0_clr_q;
        end
    end

    // S2 next state: every limb-by-limb product
    always_comb begin
        for (int unsigned i = 0; i < NL; i++) begin
            for (int unsigned j = 0; j < NL; j++) begin
                pp_d[i][j] = PP_W'(s1_op_q[i*LIMB_W +: LIMB_W]) *
                             PP_W'(s1_c_q[j*LIMB_W +: LIMB_W]);
            end
        end
    end

    // S2 register: partial products plus control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= '0;
            s2_clr_q   <= 1'b0;
            pp_q       <= '{default: '{default: '0}};
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_clr_q   <= s1_clr_q;
            pp_q       <= pp_d;
        end
    end

    // S3 next state: sum the partial products sharing each diagonal
    always_comb begin
        for (int unsigned d = 0; d < ND; d++) begin
            ds_d[d] = '0;
            for (int unsigned i = 0; i < NL; i++) begin
                for (int unsigned j = 0; j < NL; j++) begin
                    if (i + j == d) begin
                        ds_d[d] = ds_d[d] + DS_W'(pp_q[i][j]);
                    end
                end
            end
        end
    end

    // S3 register: diagonal sums plus control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_mode_q  <= '0;
            s3_clr_q   <= 1'b0;
            ds_q       <= '{default: '0};
        end else if (adv) begin
            s3_valid_q <= s2_valid_q;
            s3_mode_q  <= s2_mode_q;
            s3_clr_q   <= s2_clr_q;
            ds_q       <= ds_d;
        end
    end

    // S4 next state: weight diagonals by limb position, then optionally accumulate
    always_comb begin
        prod = '0;
        for (int unsigned d = 0; d < ND; d++) begin
            prod = prod + (OUT_W'(ds_q[d]) << (d * LIMB_W));
        end
        acc_sum   = (s3_clr_q ? '0 : acc_q) + prod;
        acc_d     = acc_q;
        out_d     = '0;
        out_acc_d = 1'b0;
        if (s3_valid_q) begin
            if (s3_mode_q[1]) begin
                acc_d     = acc_sum;
                out_d     = acc_sum;
                out_acc_d = 1'b1;
            end else begin
                out_d     = prod;
            end
        end
    end

    // S4 register: result, flags and accumulator; nothing moves while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_acc_q   <= 1'b0;
            acc_q       <= '0;
        end else if (adv) begin
            out_valid_q <= s3_valid_q;
            out_q       <= out_d;
            out_acc_q   <= out_acc_d;
            acc_q       <= acc_d;
        end
    end

    // Outputs are forced to zero whenever no result is presented
    always_comb begin
        out_valid = out_valid_q;
        out       = out_valid_q ? out_q : '0;
        out_acc   = out_valid_q && out_acc_q;
    end

endmodule

// File: tb/tb_p_mac_pipe.sv
// Scoreboard bench for p_mac_pipe: expected results are queued on acceptance and
// compared in order as the DUT presents them.
module tb_p_mac_pipe;

    localparam int unsigned IN_W  = 47;
    localparam int unsigned C_W   = 48;
    localparam int unsigned OUT_W = 96;

    typedef struct packed {
        logic             acc;
        logic [OUT_W-1:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_a = '0;
    logic [IN_W-1:0]  in_b = '0;
    logic [C_W-1:0]   in_c = '0;
    logic [1:0]       in_mode = '0;
    logic             in_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out;
    logic             out_acc;

    exp_t             exp_q [$];
    exp_t             mon_e;
    logic [OUT_W-1:0] acc_m = '0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               n_out = 0;
    int               stall_waits = 0;

    p_mac_pipe #(.IN_W(IN_W), .C_W(C_W), .LIMB_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_acc   (out_acc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_prod(input logic [IN_W-1:0] a,
                                                    input logic [IN_W-1:0] b,
                                                    input logic [C_W-1:0] c,
                                                    input logic [1:0] mode);
        logic [OUT_W-1:0] op;
        op = mode[0] ? OUT_W'(a) : OUT_W'(a) + OUT_W'(b);
        return op * OUT_W'(c);
    endfunction

    task automatic push_expected(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                 input logic [C_W-1:0] c, input logic [1:0] mode,
                                 input logic clr);
        logic [OUT_W-1:0] p;
        exp_t e;
        p = model_prod(a, b, c, mode);
        if (mode[1]) begin
            acc_m = (clr ? '0 : acc_m) + p;
            e = '{acc: 1'b1, val: acc_m};
        end else begin
            e = '{acc: 1'b0, val: p};
        end
        exp_q.push_back(e);
    endtask

    // Drive one beat from posedge+1; returns at the next posedge+1 after it transfers
    task automatic send(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                        input logic [C_W-1:0] c, input logic [1:0] mode, input logic clr);
        int w;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        in_mode = mode;
        in_clr = clr;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            stall_waits++;
            @(negedge clk);
        end
        if (!in_ready) check_val("send_timeout", 128'(in_ready), 128'(1));
        else push_expected(a, b, c, mode, clr);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_val("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every accepted result
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 128'(out), 128'(0));
                    check_val("unexpected_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("out_value", 128'(out), 128'(mon_e.val));
                    check_val("out_acc", 128'(out_acc), 128'(mon_e.acc));
                    n_out++;
                end
            end
            if (!out_valid) begin
                check_val("idle_out_zero", 128'(out), 128'(0));
                check_val("idle_out_acc_zero", 128'(out_acc), 128'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int run;
        int w;
        int sw0;
        int stale;
        logic [OUT_W-1:0] held;
        logic [IN_W-1:0] amax;
        logic [C_W-1:0] cmax;

        // Reset state
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_in_ready", 128'(in_ready), 128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_out", 128'(out), 128'(0));
        check_val("rst_out_acc", 128'(out_acc), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single (a+b)*c beat and its latency
        in_valid = 1'b1;
        in_a = 47'd3;
        in_b = 47'd4;
        in_c = 48'd5;
        in_mode = 2'b00;
        in_clr = 1'b0;
        @(negedge clk);
        check_val("t1_in_ready", 128'(in_ready), 128'(1));
        push_expected(47'd3, 47'd4, 48'd5, 2'b00, 1'b0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        check_val("t1_latency", 128'(lat), 128'(5));
        check_val("t1_out", 128'(out), 128'd35);
        drain();

        // Max operands, both product modes
        amax = '1;
        cmax = '1;
        send(amax, amax, cmax, 2'b00, 1'b0);
        send(amax, amax, cmax, 2'b01, 1'b0);
        drain();

        // Accumulate sequence: 20, 40, 7, 40
        send(47'd1, 47'd1, 48'd10, 2'b10, 1'b1);
        send(47'd2, 47'd0, 48'd10, 2'b10, 1'b0);
        send(47'd7, 47'd5, 48'd1, 2'b01, 1'b1);
        send(47'd0, 47'd9, 48'd0, 2'b11, 1'b0);
        drain();

        // Backpressure: 8 beats, out_ready low for three cycles
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(IN_W'(i), 47'd0, 48'd1, 2'b00, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = out;
                repeat (3) begin
                    @(negedge clk);
                    check_val("bp_in_ready", 128'(in_ready), 128'(0));
                    check_val("bp_out_valid", 128'(out_valid), 128'(1));
                    check_val("bp_out_held", 128'(out), 128'(held));
                end
                check_val("bp_held_zero", 128'(held), 128'(0));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_val("bp_count", 128'(n_out - n0), 128'(8));

        // Throughput: 20 back-to-back beats
        sw0 = stall_waits;
        fork
            begin
                for (int i = 0; i < 20; i++) send(IN_W'(i + 100), IN_W'(i), 48'd3, 2'b00, 1'b0);
                check_val("tp_in_ready", 128'(stall_waits - sw0), 128'(0));
            end
            begin
                w = 0;
                while (!out_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                run = 0;
                while (out_valid && run < 30) begin
                    run++;
                    @(negedge clk);
                end
                check_val("tp_run", 128'(run), 128'(20));
            end
        join
        drain();

        // Reset two cycles into a 4-beat accumulate stream
        send(47'd5, 47'd5, 48'd5, 2'b10, 1'b0);
        send(47'd6, 47'd6, 48'd6, 2'b10, 1'b0);
        in_valid = 1'b1;
        in_a = 47'd7;
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check_val("mid_rst_out", 128'(out), 128'(0));
        check_val("mid_rst_in_ready", 128'(in_ready), 128'(1));
        exp_q.delete();
        acc_m = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_val("no_stale", 128'(stale), 128'(0));
        @(posedge clk);
        #1;
        n0 = n_out;
        send(47'd1, 47'd1, 48'd1, 2'b10, 1'b0);
        drain();
        check_val("post_rst_count", 128'(n_out - n0), 128'(1));
        check_val("post_rst_acc_model", 128'(acc_m), 128'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
